// File: rtl/score_keeper.sv
// score_keeper -- match-state controller for a two-player ball game.
//
// Counts goal events from the playfield logic, runs a frame-counted pause
// with a ball re-serve after every point, and declares a winner when a
// player reaches WIN_SCORE.
//
// Parameters:
//   WIN_SCORE     points needed to win (1..63)
//   PAUSE_FRAMES  frame ticks in the post-point pause (1..255)
//
// Ports:
//   clk_i             pixel clock
//   rst_ni            asynchronous active-low reset
//   frame_tick_i      one-cycle pulse per video frame
//   start_i           one-cycle pulse, starts a new match (any state)
//   goal_player_1_i   one-cycle pulse, player 1 scored
//   goal_player_2_i   one-cycle pulse, player 2 scored
//   score_player_1_o  player 1 score, binary
//   score_player_2_o  player 2 score, binary
//   play_enable_o     high while the ball may move (PLAY)
//   serve_o           one-cycle pulse, relaunch the ball
//   game_over_o       high in OVER
//   winner_o          00 none, 01 player 1, 10 player 2
module score_keeper #(
   parameter int WIN_SCORE    = 11,
   parameter int PAUSE_FRAMES = 60
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       frame_tick_i,
   input  logic       start_i,
   input  logic       goal_player_1_i,
   input  logic       goal_player_2_i,
   output logic [5:0] score_player_1_o,
   output logic [5:0] score_player_2_o,
   output logic       play_enable_o,
   output logic       serve_o,
   output logic       game_over_o,
   output logic [1:0] winner_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAUSE = 2'd1,
      PLAY  = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [7:0] PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
   localparam logic [5:0] WIN_VAL    = 6'(WIN_SCORE);

   state_t     state_reg, state_next;
   logic [7:0] pause_cnt_reg, pause_cnt_next;
   logic [5:0] score_1_reg, score_1_next;
   logic [5:0] score_2_reg, score_2_next;
   logic [1:0] winner_reg, winner_next;
   logic       serve_reg, serve_next;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= IDLE;
         pause_cnt_reg <= 8'd0;
         score_1_reg   <= 6'd0;
         score_2_reg   <= 6'd0;
         winner_reg    <= 2'b00;
         serve_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pause_cnt_reg <= pause_cnt_next;
         score_1_reg   <= score_1_next;
         score_2_reg   <= score_2_next;
         winner_reg    <= winner_next;
         serve_reg     <= serve_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pause_cnt_next = pause_cnt_reg;
      score_1_next   = score_1_reg;
      score_2_next   = score_2_reg;
      winner_next    = winner_reg;
      serve_next     = 1'b0;

      if (start_i) begin
         // Restart wins over everything else sampled in the same cycle.
         state_next     = PAUSE;
         pause_cnt_next = 8'd0;
         score_1_next   = 6'd0;
         score_2_next   = 6'd0;
         winner_next    = 2'b00;
      end else begin
         case (state_reg)
            IDLE: begin
               score_1_next = 6'd0;
               score_2_next = 6'd0;
            end
            PAUSE: begin
               if (frame_tick_i) begin
                  if (pause_cnt_reg == PAUSE_LAST) begin
                     state_next     = PLAY;
                     serve_next     = 1'b1;
                     pause_cnt_next = 8'd0;
                  end else begin
                     pause_cnt_next = pause_cnt_reg + 8'd1;
                  end
               end
            end
            PLAY: begin
               // Every goal (including a tied double goal, which replays the
               // point) leaves PLAY; the counter is re-armed for the pause.
               if (goal_player_1_i || goal_player_2_i) begin
                  state_next     = PAUSE;
                  pause_cnt_next = 8'd0;
               end
               if (goal_player_1_i && !goal_player_2_i) begin
                  score_1_next = score_1_reg + 6'd1;
                  if (score_1_reg + 6'd1 == WIN_VAL) begin
                     state_next  = OVER;
                     winner_next = 2'b01;
                  end
               end else if (goal_player_2_i && !goal_player_1_i) begin
                  score_2_next = score_2_reg + 6'd1;
                  if (score_2_reg + 6'd1 == WIN_VAL) begin
                     state_next  = OVER;
                     winner_next = 2'b10;
                  end
               end
            end
            OVER: begin
               // Frozen until start_i.
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign score_player_1_o = score_1_reg;
   assign score_player_2_o = score_2_reg;
   assign winner_o         = winner_reg;
   assign serve_o          = serve_reg;
   assign play_enable_o    = (state_reg == PLAY);
   assign game_over_o      = (state_reg == OVER);

endmodule
